serial_word_feeder: RTL and testbench

Upstream stage for the bit-serial sequence detector. It accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and serializes them MSB-first onto a single-bit stream, one bit per enabled clock. Its str_out drives the detector's serial input directly. Bits of consecutive words follow each other with no idle gap.

---
 rtl/serial_pkg.sv | 12 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/serial_word_feeder.sv | 135 +++++++++++++
 tb/tb_serial_word_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and default sizing for the serial word feeder.
package serial_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read and registered occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/serial_word_feeder.sv
// Buffers parallel words and serializes them MSB-first, one bit per enabled clock.
//  state | meaning
//  IDLE  | no word in the shift register; pops as soon as the FIFO holds a word
//  SHIFT | shifting the current word out on each bit_en cycle
module serial_word_feeder
   import serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             bit_en_i,
   output logic             str_out_o,
   output logic             str_valid_o,
   output logic             word_done_o,
   output logic             busy_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             str_out_q, str_out_d;
   logic             str_valid_q, str_valid_d;
   logic             word_done_q, word_done_d;

   logic             fifo_push, fifo_pop;
   logic [WIDTH-1:0] fifo_rdata;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full, fifo_empty;

   // Ready is taken from the registered count only; a same-cycle pop does not free a slot.
   assign in_ready_o = (fifo_count != CW'(DEPTH));
   assign fifo_push  = in_valid_i && in_ready_o;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (in_data_i),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         bitcnt_q    <= '0;
         str_out_q   <= 1'b0;
         str_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         bitcnt_q    <= bitcnt_d;
         str_out_q   <= str_out_d;
         str_valid_q <= str_valid_d;
         word_done_q <= word_done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_en_i && (bitcnt_q == '0)) begin
               if (!fifo_empty) fifo_pop = 1'b1;
               else             state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sreg_d      = sreg_q;
      bitcnt_d    = bitcnt_q;
      str_out_d   = 1'b0;
      str_valid_d = 1'b0;
      word_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_pop) begin
               sreg_d   = fifo_rdata;
               bitcnt_d = BW'(WIDTH - 1);
            end
         end
         SHIFT: begin
            if (bit_en_i) begin
               str_out_d   = sreg_q[WIDTH-1];
               str_valid_d = 1'b1;
               if (bitcnt_q == '0) begin
                  word_done_d = 1'b1;
                  if (fifo_pop) begin
                     sreg_d   = fifo_rdata;
                     bitcnt_d = BW'(WIDTH - 1);
                  end else begin
                     sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign str_out_o   = str_out_q;
   assign str_valid_o = str_valid_q;
   assign word_done_o = word_done_q;
   assign busy_o      = (state_q == SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench: accepted words queue their expected bits, a negedge monitor checks the stream.
module tb_serial_word_feeder;

   localparam int W = 8;

   typedef struct {
      logic b;
      logic last;
   } exp_bit_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         bit_en = 1'b1;
   logic         str_out, str_valid, word_done, busy;

   exp_bit_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_word_feeder #(.WIDTH(W), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .bit_en_i    (bit_en),
      .str_out_o   (str_out),
      .str_valid_o (str_valid),
      .word_done_o (word_done),
      .busy_o      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every valid bit must match the scoreboard head; idle cycles must be quiet.
   always @(negedge clk) begin
      if (!rst) begin
         if (str_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 32'(str_valid), 32'd0);
            end else begin
               exp_bit_t e;
               e = exp_q.pop_front();
               chk("str_out", 32'(str_out), 32'(e.b));
               chk("word_done", 32'(word_done), 32'(e.last));
            end
         end else begin
            chk("idle_str_out", 32'(str_out), 32'd0);
            chk("idle_word_done", 32'(word_done), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a word until accepted; returns 1 ns after the accepting edge.
   task automatic push_word(input logic [W-1:0] w);
      int t = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && t < 500) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         chk("push_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         for (int i = W - 1; i >= 0; i--) begin
            exp_bit_t e;
            e.b    = w[i];
            e.last = (i == 0);
            exp_q.push_back(e);
         end
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 300) begin
         tick();
         t++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_str_out"}, 32'(str_out), 32'd0);
      chk({tag, "_str_valid"}, 32'(str_valid), 32'd0);
      chk({tag, "_word_done"}, 32'(word_done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #1;
      check_reset_outputs("por");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single word 0xCC: valid first after the second edge following the push.
      bit_en = 1'b1;
      push_word(8'hCC);
      chk("cc_valid_e0", 32'(str_valid), 32'd0);
      tick();
      chk("cc_valid_e1", 32'(str_valid), 32'd0);
      chk("cc_busy_e1", 32'(busy), 32'd1);
      tick();
      chk("cc_valid_e2", 32'(str_valid), 32'd1);
      drain();
      tick();
      chk("cc_valid_after", 32'(str_valid), 32'd0);

      // Back-to-back 0xA5, 0x3C: 16 contiguous valid bits.
      push_word(8'hA5);
      push_word(8'h3C);
      tick();
      chk("b2b_first_valid", 32'(str_valid), 32'd1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("b2b_contiguous", 32'(str_valid), 32'd1);
      end
      drain();

      // Backpressure with bit_en low: five accepted, sixth stalls.
      bit_en = 1'b0;
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      push_word(8'h44);
      chk("bp_ready_after4", 32'(in_ready), 32'd1);
      push_word(8'h55);
      chk("bp_ready_after5", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      fork
         push_word(8'h66);
         begin
            tick();
            tick();
            chk("bp_still_stalled", 32'(in_ready), 32'd0);
            chk("bp_no_output", 32'(str_valid), 32'd0);
            bit_en = 1'b1;
         end
      join
      drain();

      // bit_en 1,0,1,0 on 0xF0: 16 cycles with alternating valid.
      bit_en = 1'b0;
      push_word(8'hF0);
      tick();
      bit_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("en_pattern_valid", 32'(str_valid), 32'((i % 2) == 0));
         bit_en = ((i % 2) == 1);
      end
      bit_en = 1'b1;
      tick();
      chk("en_pattern_done", 32'(exp_q.size()), 32'd0);
      drain();

      // Reset mid-word after three bits of 0xFF with two words queued.
      push_word(8'hFF);
      push_word(8'h12);
      push_word(8'h34);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      tick();
      check_reset_outputs("midrst_hold");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_busy", 32'(busy), 32'd0);
         chk("post_rst_valid", 32'(str_valid), 32'd0);
      end
      push_word(8'h81);
      drain();

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
